// File: rtl/cpc_ram_pkg.sv
// Shared constants, types and the bank mapping function for the CPC expansion
// RAM controller.
package cpc_ram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_READ   = 3'd1;
    localparam state_t ST_WSETUP = 3'd2;
    localparam state_t ST_WPULSE = 3'd3;
    localparam state_t ST_WHOLD  = 3'd4;

    typedef logic [2:0] cfg_t;

    localparam cfg_t CFG_NONE = 3'd0;
    localparam cfg_t CFG_HI3  = 3'd1;
    localparam cfg_t CFG_ALL  = 3'd2;
    localparam cfg_t CFG_HI3B = 3'd3;
    localparam cfg_t CFG_P4   = 3'd4;
    localparam cfg_t CFG_P5   = 3'd5;
    localparam cfg_t CFG_P6   = 3'd6;
    localparam cfg_t CFG_P7   = 3'd7;

    localparam logic       PORT_A15 = 1'b0;
    localparam logic       PORT_A14 = 1'b1;
    localparam logic [1:0] BANK_CMD = 2'b11;

    typedef struct packed {
        logic       sel;
        logic [1:0] page;
    } map_t;

    // cfg 4..7 map quarter 1 to page cfg-4, which is simply cfg[1:0].
    function automatic map_t bank_map(input cfg_t cfg, input logic [1:0] q);
        map_t r;
        r = '{sel: 1'b0, page: 2'd0};
        case (cfg)
            CFG_NONE: r = '{sel: 1'b0, page: 2'd0};
            CFG_HI3, CFG_HI3B: begin
                if (q == 2'd3) r = '{sel: 1'b1, page: 2'd3};
            end
            CFG_ALL: r = '{sel: 1'b1, page: q};
            default: begin
                if (q == 2'd1) r = '{sel: 1'b1, page: cfg[1:0]};
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpc_sync_bus.sv
// Multi-bit flop-chain synchroniser for independent asynchronous strobes.
module cpc_sync_bus #(
    parameter int             WIDTH   = 5,
    parameter int             STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cpc_ram_bank_ctrl.sv
// Snoops the Z80 bus, keeps the 6128-style bank register and sequences the
// expansion SRAM strobes with a single clocked write pulse per Z80 write.
module cpc_ram_bank_ctrl
    import cpc_ram_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int WE_CYCLES    = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        mreq_b,
    input  logic        iorq_b,
    input  logic        rd_b,
    input  logic        wr_b,
    input  logic        m1_b,
    input  logic [15:0] addr,
    input  logic [7:0]  data,
    output logic [4:0]  sram_ahi,
    output logic        sram_cs_b,
    output logic        sram_oe_b,
    output logic        sram_we_b,
    output logic        ramdis_b,
    output logic [5:0]  bank_reg
);

    localparam int CNT_W = 8;

    logic [4:0] s_bus;
    logic       s_mreq_b, s_iorq_b, s_rd_b, s_wr_b, s_m1_b;

    cpc_sync_bus #(
        .WIDTH   (5),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (5'b11111)
    ) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .d       ({mreq_b, iorq_b, rd_b, wr_b, m1_b}),
        .q       (s_bus)
    );

    assign s_mreq_b = s_bus[4];
    assign s_iorq_b = s_bus[3];
    assign s_rd_b   = s_bus[2];
    assign s_wr_b   = s_bus[1];
    assign s_m1_b   = s_bus[0];

    logic unused_addr;
    assign unused_addr = ^addr[13:0];

    // Bank port decode; the edge flop makes one update per I/O cycle.
    logic io_wr;
    logic io_wr_p1;

    assign io_wr = !s_iorq_b && !s_wr_b && s_m1_b &&
                   (addr[15] == PORT_A15) && (addr[14] == PORT_A14);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            io_wr_p1 <= 1'b0;
            bank_reg <= 6'd0;
        end else begin
            io_wr_p1 <= io_wr;
            if (io_wr && !io_wr_p1 && (data[7:6] == BANK_CMD))
                bank_reg <= data[5:0];
        end
    end

    map_t map;
    logic mem_rd, mem_wr, wr_end;

    assign map    = bank_map(bank_reg[2:0], addr[15:14]);
    // A stray I/O write seen together with a memory request takes precedence.
    assign mem_rd = !s_mreq_b && map.sel && !s_rd_b && !io_wr;
    assign mem_wr = !s_mreq_b && map.sel && !s_wr_b && !io_wr;
    assign wr_end = s_mreq_b || s_wr_b;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sram_ahi  <= 5'd0;
            sram_cs_b <= 1'b1;
            sram_oe_b <= 1'b1;
            sram_we_b <= 1'b1;
            ramdis_b  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    sram_ahi <= {bank_reg[5:3], map.page};
                    if (mem_rd) begin
                        state     <= ST_READ;
                        sram_cs_b <= 1'b0;
                        sram_oe_b <= 1'b0;
                        ramdis_b  <= 1'b0;
                    end else if (mem_wr) begin
                        state     <= ST_WSETUP;
                        sram_cs_b <= 1'b0;
                        ramdis_b  <= 1'b0;
                        cnt       <= CNT_W'(SETUP_CYCLES);
                    end
                end
                ST_READ: begin
                    if (s_mreq_b || s_rd_b) begin
                        state     <= ST_IDLE;
                        sram_cs_b <= 1'b1;
                        sram_oe_b <= 1'b1;
                        ramdis_b  <= 1'b1;
                    end
                end
                ST_WSETUP: begin
                    if (wr_end) begin
                        state     <= ST_IDLE;
                        sram_cs_b <= 1'b1;
                        sram_we_b <= 1'b1;
                        ramdis_b  <= 1'b1;
                    end else if (cnt <= CNT_W'(1)) begin
                        state     <= ST_WPULSE;
                        sram_we_b <= 1'b0;
                        cnt       <= CNT_W'(WE_CYCLES);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WPULSE: begin
                    if (wr_end) begin
                        state     <= ST_IDLE;
                        sram_cs_b <= 1'b1;
                        sram_we_b <= 1'b1;
                        ramdis_b  <= 1'b1;
                    end else if (cnt <= CNT_W'(1)) begin
                        state     <= ST_WHOLD;
                        sram_we_b <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WHOLD: begin
                    // Long writes park here so web pulses only once.
                    if (wr_end) begin
                        state     <= ST_IDLE;
                        sram_cs_b <= 1'b1;
                        ramdis_b  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sram_cs_b <= 1'b1;
                    sram_oe_b <= 1'b1;
                    sram_we_b <= 1'b1;
                    ramdis_b  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Directed bench for cpc_ram_bank_ctrl: bank port decode, read/write strobe
// sequencing, aborts, refresh, disabled config and asynchronous reset.
module tb_cpc_ram_bank_ctrl;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        mreq_b, iorq_b, rd_b, wr_b, m1_b;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [4:0]  sram_ahi;
    logic        sram_cs_b, sram_oe_b, sram_we_b, ramdis_b;
    logic [5:0]  bank_reg;

    int checks = 0;
    int errors = 0;

    int cs_first, cs_low, we_first, we_len, we_falls, oe_low, both_low, rdis_low;
    logic [4:0] ahi_seen;
    logic       cs_end;

    cpc_ram_bank_ctrl #(
        .SYNC_STAGES  (2),
        .WE_CYCLES    (2),
        .SETUP_CYCLES (1)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .mreq_b    (mreq_b),
        .iorq_b    (iorq_b),
        .rd_b      (rd_b),
        .wr_b      (wr_b),
        .m1_b      (m1_b),
        .addr      (addr),
        .data      (data),
        .sram_ahi  (sram_ahi),
        .sram_cs_b (sram_cs_b),
        .sram_oe_b (sram_oe_b),
        .sram_we_b (sram_we_b),
        .ramdis_b  (ramdis_b),
        .bank_reg  (bank_reg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d);
        addr   = a;
        data   = d;
        iorq_b = 1'b0;
        wr_b   = 1'b0;
        repeat (6) @(negedge clk);
        iorq_b = 1'b1;
        wr_b   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // mode 0 read, 1 write, 2 refresh; all strobes rise after sample 'hold',
    // wr_b alone rises after sample 'wr_rel' when nonzero.
    task automatic mem_cycle(input int mode, input logic [15:0] a, input int hold,
                             input int wr_rel, input int win);
        logic prev_we;
        cs_first = -1; cs_low = 0; we_first = -1; we_len = 0; we_falls = 0;
        oe_low = 0; both_low = 0; rdis_low = 0; ahi_seen = 5'd0; prev_we = 1'b1;
        addr   = a;
        mreq_b = 1'b0;
        if (mode == 0) rd_b = 1'b0;
        if (mode == 1) wr_b = 1'b0;
        for (int k = 1; k <= win; k++) begin
            @(negedge clk);
            if (!sram_cs_b) begin
                cs_low++;
                if (cs_first < 0) begin
                    cs_first = k;
                    ahi_seen = sram_ahi;
                end
            end
            if (!sram_we_b) begin
                we_len++;
                if (we_first < 0) we_first = k;
            end
            if (prev_we && !sram_we_b) we_falls++;
            prev_we = sram_we_b;
            if (!sram_oe_b) oe_low++;
            if (!sram_oe_b && !sram_we_b) both_low++;
            if (!ramdis_b) rdis_low++;
            if (k == wr_rel) wr_b = 1'b1;
            if (k == hold) begin
                mreq_b = 1'b1;
                rd_b   = 1'b1;
                wr_b   = 1'b1;
            end
        end
        cs_end = sram_cs_b;
    endtask

    initial begin
        reset_b = 1'b0;
        mreq_b = 1'b1; iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
        addr = 16'h0000; data = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_bank", bank_reg, 6'd0);
        check_val("rst_cs", sram_cs_b, 1'b1);
        check_val("rst_oe", sram_oe_b, 1'b1);
        check_val("rst_we", sram_we_b, 1'b1);
        check_val("rst_ramdis", ramdis_b, 1'b1);
        check_val("rst_ahi", sram_ahi, 5'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        io_write(16'h7F00, 8'hC5);
        check_val("bank_c5", bank_reg, 6'b000101);

        mem_cycle(0, 16'h4000, 6, 0, 12);
        check_val("rd4000_csfirst", cs_first, 3);
        check_val("rd4000_ahi", ahi_seen, 5'b00001);
        check_val("rd4000_oelow", oe_low, 6);
        check_val("rd4000_cslow", cs_low, 6);
        check_val("rd4000_ramdis", rdis_low, 6);
        check_val("rd4000_we", we_len, 0);
        check_val("rd4000_csend", cs_end, 1'b1);

        mem_cycle(0, 16'h8000, 6, 0, 12);
        check_val("rd8000_cslow", cs_low, 0);
        check_val("rd8000_oelow", oe_low, 0);
        check_val("rd8000_ramdis", rdis_low, 0);

        io_write(16'h7F00, 8'h45);
        check_val("bank_ign_cmd", bank_reg, 6'b000101);
        io_write(16'hBF00, 8'hC2);
        check_val("bank_ign_a14", bank_reg, 6'b000101);

        io_write(16'h7F00, 8'hFA);
        check_val("bank_fa", bank_reg, 6'b111010);

        mem_cycle(1, 16'hC123, 10, 0, 20);
        check_val("wr_csfirst", cs_first, 3);
        check_val("wr_ahi", ahi_seen, 5'b11111);
        check_val("wr_wefirst", we_first, 4);
        check_val("wr_welen", we_len, 2);
        check_val("wr_wefalls", we_falls, 1);
        check_val("wr_cslow", cs_low, 10);
        check_val("wr_oelow", oe_low, 0);
        check_val("wr_excl", both_low, 0);
        check_val("wr_csend", cs_end, 1'b1);

        mem_cycle(1, 16'hC123, 8, 1, 12);
        check_val("abort_cslow", cs_low, 1);
        check_val("abort_welen", we_len, 0);
        check_val("abort_csend", cs_end, 1'b1);
        check_val("abort_weend", sram_we_b, 1'b1);

        mem_cycle(2, 16'h4000, 6, 0, 12);
        check_val("refresh_cslow", cs_low, 0);
        check_val("refresh_oelow", oe_low, 0);
        check_val("refresh_welen", we_len, 0);

        io_write(16'h7F00, 8'hC0);
        check_val("bank_c0", bank_reg, 6'b000000);
        mem_cycle(0, 16'hC000, 6, 0, 12);
        check_val("cfg0_rd_cslow", cs_low, 0);
        check_val("cfg0_rd_ramdis", rdis_low, 0);
        mem_cycle(1, 16'h4000, 6, 0, 12);
        check_val("cfg0_wr_cslow", cs_low, 0);
        check_val("cfg0_wr_welen", we_len, 0);
        check_val("cfg0_wr_ramdis", rdis_low, 0);

        io_write(16'h7F00, 8'hFA);
        addr   = 16'hC123;
        mreq_b = 1'b0;
        wr_b   = 1'b0;
        repeat (4) @(negedge clk);
        check_val("midpulse_we", sram_we_b, 1'b0);
        reset_b = 1'b0;
        #1;
        check_val("rstmid_we", sram_we_b, 1'b1);
        check_val("rstmid_cs", sram_cs_b, 1'b1);
        check_val("rstmid_bank", bank_reg, 6'd0);
        mreq_b = 1'b1;
        wr_b   = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
